mem_stage: RTL and testbench

- Pipeline MEM stage of the RISC-V core, sitting between EX and WB.
- Converts each EX load/store into one request on the memory-controller data port (mm_e/mm_a/mm_wr/mm_cu/mm_n_i, answered by mm_ok/mm_n_o).
- Stalls the pipeline until the controller answers, then sign- or zero-extends load data and presents a single writeback.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_stage_load_ext.sv | 25 ++
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: op codes, FSM encoding,
// controller byte-count codes and op classification helpers.
package mem_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  // Byte count minus one, as the controller expects it on mm_cu.
  localparam logic [1:0] MM_CU_BYTE = 2'd0;
  localparam logic [1:0] MM_CU_HALF = 2'd1;
  localparam logic [1:0] MM_CU_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Transfer size of a memory op; only meaningful for loads/stores.
  function automatic logic [1:0] cu_of(input logic [3:0] op);
    logic [1:0] cu;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: cu = MM_CU_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: cu = MM_CU_HALF;
      default:                 cu = MM_CU_WORD;
    endcase
    return cu;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Combinational load extender: narrows the raw controller word to the
// access size and sign- or zero-extends it; upper raw bytes are ignored.
module load_ext
  import mem_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] raw,
  output logic [W-1:0] ext
);

  // Select extension rule by op; word loads and non-loads pass raw through
  always_comb begin
    ext = raw;
    case (op)
      MEM_LB:  ext = {{(W-8){raw[7]}}, raw[7:0]};
      MEM_LBU: ext = {{(W-8){1'b0}}, raw[7:0]};
      MEM_LH:  ext = {{(W-16){raw[15]}}, raw[15:0]};
      MEM_LHU: ext = {{(W-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns EX loads/stores into one memory-controller
// request each, stalls until the controller answers, then issues a single
// writeback. Non-memory ops are forwarded to WB one cycle later.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [ADDR_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_rd_we,
  output logic              stall,
  output logic              mm_e,
  output logic [ADDR_W-1:0] mm_a,
  output logic              mm_wr,
  output logic [1:0]        mm_cu,
  output logic [ADDR_W-1:0] mm_n_i,
  input  logic              mm_ok,
  input  logic [ADDR_W-1:0] mm_n_o,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_data
);

  state_t             state;
  logic [3:0]         op_q;
  logic [REG_W-1:0]   rd_q;
  logic               rd_we_q;
  logic [ADDR_W-1:0]  ext_data;
  logic               ex_is_mem;

  assign ex_is_mem = is_load(ex_mem_op) || is_store(ex_mem_op);

  // Busy while a transaction is open; also hold EX off when a memory op
  // arrives but the controller still shows a stale done from before.
  assign stall = (state != IDLE) || (ex_valid && ex_is_mem && mm_ok);

  load_ext #(.W(ADDR_W)) u_load_ext (
    .op  (op_q),
    .raw (mm_n_o),
    .ext (ext_data)
  );

  // Request/response FSM with all controller and writeback outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= MEM_NONE;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
      mm_e     <= 1'b0;
      mm_a     <= '0;
      mm_wr    <= 1'b0;
      mm_cu    <= MM_CU_BYTE;
      mm_n_i   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !ex_is_mem) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
            wb_we    <= ex_rd_we;
            wb_data  <= ex_wdata;
          end else if (ex_valid && !mm_ok) begin
            op_q    <= ex_mem_op;
            rd_q    <= ex_rd;
            rd_we_q <= ex_rd_we;
            mm_e    <= 1'b1;
            mm_a    <= ex_addr;
            mm_wr   <= is_store(ex_mem_op);
            mm_cu   <= cu_of(ex_mem_op);
            mm_n_i  <= ex_wdata;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mm_ok) begin
            mm_e     <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_we    <= is_load(op_q) ? rd_we_q : 1'b0;
            wb_data  <= is_load(op_q) ? ext_data : '0;
            state    <= DROP;
          end
        end
        DROP: begin
          // Wait for the controller to retire its done flag so the next
          // request starts on a clean mm_e edge.
          if (!mm_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural memory controller and
// scoreboards for expected requests and expected writebacks.
module tb_mem_stage;
  import mem_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  cu;
    logic [31:0] wdata;
  } req_t;

  typedef enum int {M_IDLE, M_WAIT, M_OK, M_HOLD} model_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_rd_we = 1'b0;
  logic        stall;
  logic        mm_e;
  logic [31:0] mm_a;
  logic        mm_wr;
  logic [1:0]  mm_cu;
  logic [31:0] mm_n_i;
  logic        mm_ok = 1'b0;
  logic [31:0] mm_n_o = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;
  int wb_count = 0;
  int resp_delay = 6;
  int resp_hold = 0;

  wb_t    wb_q[$];
  req_t   req_q[$];
  logic [31:0] resp_q[$];
  model_t mstate = M_IDLE;

  mem_stage #(.ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .stall(stall),
    .mm_e(mm_e), .mm_a(mm_a), .mm_wr(mm_wr), .mm_cu(mm_cu), .mm_n_i(mm_n_i),
    .mm_ok(mm_ok), .mm_n_o(mm_n_o),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [3:0] op, input logic [31:0] r);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = r[7:0];
    h = r[15:0];
    case (op)
      4'd1:    return 32'(b);
      4'd2:    return 32'(h);
      4'd4:    return r & 32'h0000_00FF;
      4'd5:    return r & 32'h0000_FFFF;
      default: return r;
    endcase
  endfunction

  function automatic logic [1:0] model_cu(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 2'd0;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2'd1;
    return 2'd3;
  endfunction

  // Controller model plus monitors, all evaluated at the falling edge
  initial begin
    logic   prev_mm_e;
    req_t   cur;
    wb_t    w;
    int     cnt;
    logic [31:0] resp_cur;
    prev_mm_e = 1'b0;
    cur = '0;
    cnt = 0;
    resp_cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mstate = M_IDLE;
        mm_ok = 1'b0;
        prev_mm_e = 1'b0;
      end else begin
        // request monitor
        if (mm_e === 1'b1 && prev_mm_e !== 1'b1) begin
          chk("mm_e_rise_with_ok_low", {31'd0, mm_ok}, 32'd0);
          if (req_q.size() == 0) begin
            chk("unexpected_request", 32'd1, 32'd0);
          end else begin
            cur = req_q.pop_front();
            chk("mm_a", mm_a, cur.addr);
            chk("mm_wr", {31'd0, mm_wr}, {31'd0, cur.wr});
            chk("mm_cu", {30'd0, mm_cu}, {30'd0, cur.cu});
            chk("mm_n_i", mm_n_i, cur.wdata);
          end
          resp_cur = (resp_q.size() != 0) ? resp_q.pop_front() : 32'd0;
          $display("req addr=%08h wr=%0d cu=%0d wdata=%08h", mm_a, mm_wr, mm_cu, mm_n_i);
        end else if (mm_e === 1'b1) begin
          chk("mm_a_held", mm_a, cur.addr);
          chk("mm_n_i_held", mm_n_i, cur.wdata);
          chk("mm_cu_held", {30'd0, mm_cu}, {30'd0, cur.cu});
        end
        if (mm_e === 1'b1) chk("stall_in_flight", {31'd0, stall}, 32'd1);
        // writeback monitor
        if (wb_valid === 1'b1) begin
          wb_count++;
          $display("wb rd=%0d we=%0d data=%08h", wb_rd, wb_we, wb_data);
          if (wb_q.size() == 0) begin
            chk("unexpected_writeback", 32'd1, 32'd0);
          end else begin
            w = wb_q.pop_front();
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
            chk("wb_we", {31'd0, wb_we}, {31'd0, w.we});
            chk("wb_data", wb_data, w.data);
          end
        end
        prev_mm_e = mm_e;
        // controller behaviour
        case (mstate)
          M_IDLE: if (mm_e === 1'b1) begin cnt = 0; mstate = M_WAIT; end
          M_WAIT: begin
            cnt++;
            if (cnt >= resp_delay) begin
              mm_ok = 1'b1;
              mm_n_o = resp_cur;
              mstate = M_OK;
            end
          end
          M_OK: if (mm_e === 1'b0) begin
            cnt = 0;
            if (resp_hold == 0) begin mm_ok = 1'b0; mstate = M_IDLE; end
            else mstate = M_HOLD;
          end
          M_HOLD: begin
            cnt++;
            if (cnt >= resp_hold) begin mm_ok = 1'b0; mstate = M_IDLE; end
          end
          default: mstate = M_IDLE;
        endcase
      end
    end
  end

  // Present one instruction, record its expectations, hold it until consumed
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic we, input logic [31:0] resp);
    bit ld, st, taken;
    ld = (op >= 4'd1 && op <= 4'd5);
    st = (op >= 4'd6 && op <= 4'd8);
    if (ld || st) begin
      req_q.push_back('{addr: addr, wr: st, cu: model_cu(op), wdata: wdata});
      resp_q.push_back(resp);
    end
    if (ld)      wb_q.push_back('{rd: rd, we: we, data: model_ext(op, resp)});
    else if (st) wb_q.push_back('{rd: rd, we: 1'b0, data: 32'd0});
    else         wb_q.push_back('{rd: rd, we: we, data: wdata});
    ex_mem_op = op; ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_rd_we = we;
    ex_valid = 1'b1;
    taken = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (stall === 1'b0) begin
        @(negedge clk);
        taken = 1;
        break;
      end
      @(negedge clk);
    end
    ex_valid = 1'b0;
    if (!taken) chk("issue_timeout", 32'd1, 32'd0);
  endtask

  // Let all outstanding work finish, bounded
  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (wb_q.size() == 0 && req_q.size() == 0 && mstate == M_IDLE && stall === 1'b0) begin
        done = 1;
        break;
      end
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base;
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_mm_e", {31'd0, mm_e}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_mm_wr", {31'd0, mm_wr}, 32'd0);
    chk("rst_mm_cu", {30'd0, mm_cu}, 32'd0);
    chk("rst_mm_a", mm_a, 32'd0);
    chk("rst_mm_n_i", mm_n_i, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // pass-through ops, including an unused op code
    issue(4'd0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 32'h0);
    chk("pass_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("pass_stall", {31'd0, stall}, 32'd0);
    issue(4'd12, 32'h0, 32'h0000_CAFE, 5'd7, 1'b0, 32'h0);
    drain();

    // loads with a 6-cycle controller
    resp_delay = 6; resp_hold = 0;
    issue(4'd1, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 32'h0000_00F0);
    drain();
    issue(4'd5, 32'h0000_2001, 32'h0, 5'd4, 1'b1, 32'hAAAA_8001);
    issue(4'd3, 32'h0000_2003, 32'h0, 5'd6, 1'b1, 32'hDEAD_BEEF);
    issue(4'd2, 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b1, 32'h0001_8001);
    drain();

    // store: no register write, data field cleared
    issue(4'd8, 32'h0003_0000, 32'h1122_3344, 5'd9, 1'b1, 32'hFFFF_FFFF);
    drain();

    // back-to-back with controller holding mm_ok an extra cycle
    resp_delay = 2; resp_hold = 1;
    base = wb_count;
    issue(4'd6, 32'h0000_0005, 32'h1234_56AB, 5'd1, 1'b1, 32'h0);
    issue(4'd4, 32'h0000_0006, 32'h0, 5'd2, 1'b1, 32'h0000_7F80);
    drain();
    chk("b2b_pulse_count", 32'(wb_count - base), 32'd2);

    // reset while a request is outstanding
    resp_delay = 20; resp_hold = 0;
    base = wb_count;
    req_q.push_back('{addr: 32'h40, wr: 1'b0, cu: 2'd3, wdata: 32'h0});
    resp_q.push_back(32'h5555_5555);
    ex_mem_op = 4'd3; ex_addr = 32'h40; ex_wdata = 32'h0; ex_rd = 5'd10; ex_rd_we = 1'b1;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_mm_e", {31'd0, mm_e}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mm_e", {31'd0, mm_e}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    resp_q.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_wb_after_rst", 32'(wb_count - base), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);

    // recovery after reset
    resp_delay = 3;
    issue(4'd7, 32'h0000_0010, 32'hBEEF_0102, 5'd11, 1'b1, 32'h0);
    issue(4'd0, 32'h0, 32'h0000_0042, 5'd12, 1'b1, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
